// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: round-robin owner of the shared L2 port for the L1
// instruction- and data-cache miss handlers. The owner keeps the bus for as
// long as it holds a request, can hand off between read and write without a
// gap, and every change of owner passes through one dead turnaround cycle.
module l2_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_rd_req,
  input  logic              p1_rd_req,
  input  logic              p0_wr_req,
  input  logic              p1_wr_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p0_wr_en,
  input  logic              p1_wr_en,
  input  logic [DATA_W-1:0] p0_wr_data,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p0_rd_granted,
  output logic              p1_rd_granted,
  output logic              p0_wr_granted,
  output logic              p1_wr_granted,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              arb_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_GNT = 2'd1,
    WR_GNT = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_last;
  logic   w_owner_nxt;
  logic   w_last_nxt;

  logic              w_pend0;
  logic              w_pend1;
  logic              w_sel;
  logic              w_sel_rd;
  logic              w_own_rd;
  logic              w_own_wr;
  logic              w_own_wr_en;
  logic [ADDR_W-1:0] w_own_addr;
  logic [DATA_W-1:0] w_own_wr_data;
  logic              w_in_rd;
  logic              w_in_wr;

  assign w_pend0 = p0_rd_req | p0_wr_req;
  assign w_pend1 = p1_rd_req | p1_wr_req;

  // On a tie the port that was not granted last time wins; otherwise the
  // single pending port is taken (port 0 when neither is pending, unused).
  assign w_sel    = (w_pend0 & w_pend1) ? ~r_last : w_pend1;
  assign w_sel_rd = w_sel ? p1_rd_req : p0_rd_req;

  // Current owner's request view; the other port is not looked at while granted.
  assign w_own_rd      = r_owner ? p1_rd_req  : p0_rd_req;
  assign w_own_wr      = r_owner ? p1_wr_req  : p0_wr_req;
  assign w_own_wr_en   = r_owner ? p1_wr_en   : p0_wr_en;
  assign w_own_addr    = r_owner ? p1_addr    : p0_addr;
  assign w_own_wr_data = r_owner ? p1_wr_data : p0_wr_data;

  // Next-state logic: arbitrate from IDLE/TURN, hold or hand off while granted.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE, TURN: begin
        if (w_pend0 | w_pend1) begin
          // Read wins inside a port so a line fill precedes its write-through.
          w_state_nxt = w_sel_rd ? RD_GNT : WR_GNT;
          w_owner_nxt = w_sel;
          w_last_nxt  = w_sel;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_GNT: begin
        if (!w_own_rd) begin
          w_state_nxt = w_own_wr ? WR_GNT : TURN;
        end
      end
      WR_GNT: begin
        if (w_own_rd) begin
          w_state_nxt = RD_GNT;
        end else if (!w_own_wr) begin
          w_state_nxt = TURN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; last starts at 1 so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_in_rd = (r_state == RD_GNT);
  assign w_in_wr = (r_state == WR_GNT);

  assign p0_rd_granted = w_in_rd & ~r_owner;
  assign p1_rd_granted = w_in_rd &  r_owner;
  assign p0_wr_granted = w_in_wr & ~r_owner;
  assign p1_wr_granted = w_in_wr &  r_owner;
  assign arb_busy      = w_in_rd | w_in_wr;

  // L2 port mux: only the owner's signals reach memory, zeros otherwise.
  assign mem_addr    = (w_in_rd | w_in_wr) ? w_own_addr : '0;
  assign mem_rd_en   = w_in_rd & w_own_rd;
  assign mem_wr_en   = w_in_wr & w_own_wr_en;
  assign mem_wr_data = mem_wr_en ? w_own_wr_data : '0;
  assign rd_data     = mem_rd_data;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter: directed scenarios plus a randomized run checked
// against a grant-ownership model kept in the bench.
module tb_l2_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req [2];
  logic        wr_req [2];
  logic        wr_en  [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] mem_rd_data;

  logic        p0_rd_granted, p1_rd_granted, p0_wr_granted, p1_wr_granted;
  logic [31:0] rd_data, mem_addr, mem_wr_data;
  logic        mem_rd_en, mem_wr_en, arb_busy;
  logic [3:0]  gnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: current owner (-1 none), whether it holds a read, last granted port.
  int m_owner;
  bit m_rd;
  int m_last;

  always #5 clk = ~clk;

  assign gnt = {p1_wr_granted, p1_rd_granted, p0_wr_granted, p0_rd_granted};

  l2_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_rd_req    (rd_req[0]),
    .p1_rd_req    (rd_req[1]),
    .p0_wr_req    (wr_req[0]),
    .p1_wr_req    (wr_req[1]),
    .p0_addr      (addr[0]),
    .p1_addr      (addr[1]),
    .p0_wr_en     (wr_en[0]),
    .p1_wr_en     (wr_en[1]),
    .p0_wr_data   (wdata[0]),
    .p1_wr_data   (wdata[1]),
    .p0_rd_granted(p0_rd_granted),
    .p1_rd_granted(p1_rd_granted),
    .p0_wr_granted(p0_wr_granted),
    .p1_wr_granted(p1_wr_granted),
    .rd_data      (rd_data),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .arb_busy     (arb_busy)
  );

  // One clock: advance the ownership model from the inputs seen at the edge.
  task automatic cyc();
    int o;
    int lst;
    bit r;
    bit pa;
    bit pb;
    o = m_owner; r = m_rd; lst = m_last;
    pa = rd_req[0] | wr_req[0];
    pb = rd_req[1] | wr_req[1];
    if (!rst_n) begin
      o = -1; r = 0; lst = 1;
    end else if (m_owner >= 0) begin
      if (m_rd) begin
        if (!rd_req[m_owner]) begin
          if (wr_req[m_owner]) r = 0;
          else o = -1;
        end
      end else begin
        if (rd_req[m_owner]) r = 1;
        else if (!wr_req[m_owner]) o = -1;
      end
    end else if (pa || pb) begin
      if (pa && pb) o = 1 - m_last;
      else o = pb ? 1 : 0;
      r   = rd_req[o];
      lst = o;
    end
    @(posedge clk);
    m_owner = o; m_rd = r; m_last = lst;
    #1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      rd_req[p] = 0; wr_req[p] = 0; wr_en[p] = 0;
      addr[p] = 32'h0; wdata[p] = 32'h0;
    end
    mem_rd_data = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rd_req[0] = 1; wr_req[1] = 1; wr_en[1] = 1;
    addr[0] = 32'h1111_0000; wdata[1] = 32'h5555_AAAA;
    rst_n = 0;
    cyc();
    cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_grants: got %b expected %b", gnt, 4'b0000); end
    n_checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_enables: got rd=%b wr=%b expected 0/0", mem_rd_en, mem_wr_en); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_checks++; if (mem_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wr_data); end
    n_checks++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", arb_busy); end
    rst_n = 1;
  endtask

  task automatic test_single_read();
    do_reset();
    rd_req[0] = 1; addr[0] = 32'h0000_1000; addr[1] = 32'hABCD_0000;
    for (int i = 0; i < 9; i++) begin
      cyc();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_grant[%0d]: got %b expected 0001", i, gnt); end
      n_checks++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en[%0d]: got %b expected 1", i, mem_rd_en); end
      n_checks++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr[%0d]: got %h expected 00001000", i, mem_addr); end
    end
    rd_req[0] = 0;
    cyc();
    n_checks++; if (gnt !== 4'b0000 || mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_release: got gnt=%b rd_en=%b expected 0000/0", gnt, mem_rd_en); end
  endtask

  task automatic test_contention();
    do_reset();
    rd_req[0] = 1; rd_req[1] = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL contend_p0[%0d]: got %b expected 0001", i, gnt); end
    end
    rd_req[0] = 0;
    cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL contend_turn: got %b expected 0000", gnt); end
    cyc();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL contend_p1: got %b expected 0100", gnt); end
    cyc();
    rd_req[1] = 0; rd_req[0] = 1;
    cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL contend_turn2: got %b expected 0000", gnt); end
    rd_req[1] = 1;
    cyc();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL contend_alternate: got %b expected 0001", gnt); end
  endtask

  task automatic test_fill_then_write();
    do_reset();
    rd_req[1] = 1; addr[1] = 32'h0000_2000;
    cyc();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL fill_grant: got %b expected 0100", gnt); end
    rd_req[0] = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL fill_hold[%0d]: got %b expected 0100", i, gnt); end
    end
    rd_req[1] = 0; wr_req[1] = 1; wr_en[1] = 1; wdata[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wt_grant[%0d]: got %b expected 1000", i, gnt); end
      n_checks++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL wt_en[%0d]: got wr=%b rd=%b expected 1/0", i, mem_wr_en, mem_rd_en); end
      n_checks++; if (mem_wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wt_data[%0d]: got %h expected deadbeef", i, mem_wr_data); end
      n_checks++; if (mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL wt_addr[%0d]: got %h expected 00002000", i, mem_addr); end
    end
    wr_req[1] = 0; wr_en[1] = 0;
    cyc();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wt_turn: got %b expected 0000", gnt); end
    cyc();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wt_p0_after: got %b expected 0001", gnt); end
  endtask

  task automatic test_nonowner_ignored();
    do_reset();
    rd_req[0] = 1; addr[0] = 32'h0000_3000;
    cyc();
    wr_req[1] = 1; wr_en[1] = 1; wdata[1] = 32'h1234_5678; addr[1] = 32'h0000_4000;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL nonowner_grant[%0d]: got %b expected 0001", i, gnt); end
      n_checks++; if (mem_wr_en !== 1'b0 || mem_wr_data !== 32'h0) begin n_fail++; $display("FAIL nonowner_wr[%0d]: got en=%b data=%h expected 0/0", i, mem_wr_en, mem_wr_data); end
      n_checks++; if (mem_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL nonowner_addr[%0d]: got %h expected 00003000", i, mem_addr); end
    end
    rd_req[0] = 0;
    cyc();
    n_checks++; if (gnt !== 4'b0000 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL nonowner_turn: got gnt=%b wr_en=%b expected 0000/0", gnt, mem_wr_en); end
    cyc();
    n_checks++; if (gnt !== 4'b1000 || mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL nonowner_win: got gnt=%b wr_en=%b expected 1000/1", gnt, mem_wr_en); end
    n_checks++; if (mem_wr_data !== 32'h1234_5678 || mem_addr !== 32'h0000_4000) begin n_fail++; $display("FAIL nonowner_data: got data=%h addr=%h expected 12345678/00004000", mem_wr_data, mem_addr); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rd_req[0] = 1; addr[0] = 32'h0000_5000;
    for (int i = 0; i < 4; i++) cyc();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_beat4: got %b expected 0001", gnt); end
    rst_n = 0;
    cyc();
    n_checks++; if (gnt !== 4'b0000 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: got gnt=%b rd=%b wr=%b expected 0000/0/0", gnt, mem_rd_en, mem_wr_en); end
    n_checks++; if (arb_busy !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b addr=%h expected 0/0", arb_busy, mem_addr); end
    rst_n = 1;
    cyc();
    n_checks++; if (gnt !== 4'b0001 || mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL midrst_regrant: got gnt=%b rd=%b expected 0001/1", gnt, mem_rd_en); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      addr[0] = $urandom; addr[1] = $urandom; wdata[0] = $urandom; wdata[1] = $urandom;
      wr_en[0] = 1'($urandom); wr_en[1] = 1'($urandom);
      cyc();
      n_checks++; if (arb_busy !== 1'b0 || mem_addr !== 32'h0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL idle[%0d]: got busy=%b addr=%h rd=%b wr=%b expected 0/0/0/0", i, arb_busy, mem_addr, mem_rd_en, mem_wr_en);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  e_gnt;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(5) == 0) rd_req[p] = ~rd_req[p];
        if ($urandom_range(5) == 0) wr_req[p] = ~wr_req[p];
        wr_en[p] = 1'($urandom);
        addr[p]  = $urandom;
        wdata[p] = $urandom;
      end
      mem_rd_data = $urandom;
      rst_n = ($urandom_range(199) != 0);
      cyc();
      e_gnt = 4'b0000; e_rd = 0; e_wr = 0; e_addr = 32'h0; e_wdata = 32'h0;
      if (m_owner >= 0) begin
        e_gnt[m_owner * 2 + (m_rd ? 0 : 1)] = 1'b1;
        e_rd   = m_rd & rd_req[m_owner];
        e_wr   = !m_rd & wr_en[m_owner];
        e_addr = addr[m_owner];
        if (e_wr) e_wdata = wdata[m_owner];
      end
      n_checks++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b expected %b", i, gnt, e_gnt); end
      n_checks++; if (mem_rd_en !== e_rd || mem_wr_en !== e_wr) begin n_fail++; $display("FAIL rand_en[%0d]: got rd=%b wr=%b expected %b/%b", i, mem_rd_en, mem_wr_en, e_rd, e_wr); end
      n_checks++; if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, mem_addr, e_addr); end
      n_checks++; if (mem_wr_data !== e_wdata) begin n_fail++; $display("FAIL rand_wdata[%0d]: got %h expected %h", i, mem_wr_data, e_wdata); end
      n_checks++; if (arb_busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, arb_busy, (m_owner >= 0)); end
      n_checks++; if (rd_data !== mem_rd_data) begin n_fail++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", i, rd_data, mem_rd_data); end
    end
    rst_n = 1;
  endtask

  initial begin
    m_owner = -1; m_rd = 0; m_last = 1;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_fill_then_write();
    test_nonowner_ignored();
    test_reset_mid_burst();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
